int_to_fp: RTL
==============

// Module: int_to_fp
// PURPOSE
//   Multi-cycle converter from a 32-bit integer (signed or unsigned) to an
//   IEEE-754 single-precision float, rounded to nearest-even.
//   Produces the packed operands consumed by the FP adder/multiplier path.
//   Normalisation uses an iterative left-shift state machine.
//   Valid/ready handshake on both sides; one conversion in flight at a time.
// PARAMETERS
//   SHIFT_STEP  1    max left-shift bits per NORM cycle (legal: 1,2,4,8)
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   rst          in   1   synchronous reset, active-high
//   in_valid     in   1   in_data/in_signed valid
//   in_ready     out  1   converter can accept an operand
//   in_data      in   32  integer operand
//   in_signed    in   1   1: in_data is two's complement; 0: unsigned
//   out_valid    out  1   out_data/out_inexact valid
//   out_ready    in   1   consumer accepts result
//   out_data     out  32  IEEE-754 single result {sign,exp[7:0],mant[22:0]}
//   out_inexact  out  1   1 when rounding discarded nonzero bits
// BEHAVIOUR
//   Reset: state IDLE; in_ready=1, out_valid=0, out_data=0, out_inexact=0.
//     Reset mid-conversion discards the operand; no result is emitted.
//   States: IDLE -> NORM -> ROUND -> DONE -> IDLE (zero: IDLE -> DONE).
//   IDLE: in_ready=1. On in_valid&in_ready edge capture:
//     sign = in_signed & in_data[31]; mag = sign ? -in_data : in_data
//     (32-bit unsigned; signed 0x80000000 gives mag=2^31); exp = 158.
//     mag==0 -> DONE, result 0x00000000, inexact 0 (never -0). Else -> NORM.
//   NORM: in_ready=0. w = leading zeros in mag[31:32-SHIFT_STEP].
//     w==0 (mag[31]=1) -> ROUND; else mag<<=w, exp-=w, stay NORM.
//   ROUND: mant=mag[30:8], g=mag[7], s=|mag[6:0].
//     up = g & (s | mag[8]); mant+=up; mantissa carry-out -> mant=0, exp+=1.
//     inexact = g|s. exp max 159: no overflow/inf/denormal cases exist.
//     Register out_data={sign,exp,mant}, out_inexact; -> DONE.
//   DONE: out_valid=1; out_data/out_inexact held stable until
//     out_valid&out_ready edge -> IDLE (out_valid=0 next cycle).
//     in_ready=0 in all states except IDLE; no input/output overlap.
//   Latency (SHIFT_STEP=1), accept edge E0, lz = leading zeros of mag:
//     out_valid first high after edge E0+lz+2; zero input: after E0+1.
//   Between conversions out_data holds last result (don't-care to consumer).
// TESTING
//   1 signed 0x00002710 (10000) -> 0x461C4000, inexact 0, out_valid after
//     edge E0+20; unsigned same input -> same result.
//   2 signed 0xFFFFE0C0 (-8000) -> 0xC5FA0000; signed 0x80000000 -> 0xCF000000.
//   3 0x00000000 (either mode) -> 0x00000000, inexact 0, out_valid after E0+1.
//   4 unsigned 0xFFFFFFFF -> 0x4F800000, inexact 1 (round carries into exp);
//     unsigned 0x80000000 -> 0x4F000000, inexact 0.
//   5 ties: 0x01000001 -> 0x4B800000 inexact 1 (even, down);
//     0x01000003 -> 0x4B800002 inexact 1 (odd, up).
//   6 hold out_ready=0 5 cycles: out_data stable, in_ready=0, new in_valid
//     ignored; rst during NORM -> next cycle out_valid=0, in_ready=1.

Source files
------------

// File: rtl/int_to_fp_if.sv
// Purpose: operand/result handshake bundle for the integer-to-float converter.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
interface int_to_fp_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    // Producer/consumer of the converter
    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

    // The converter itself
    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/int_to_fp.sv
// Purpose: 32-bit signed/unsigned integer to IEEE-754 single, round-to-nearest-even.
// Latency: accept edge + lz/SHIFT_STEP NORM steps + 2 edges to out_valid; zero input takes 1 edge.
// Backpressure: one operand in flight; in_ready only in IDLE, result held until out_ready.
module int_to_fp #(
    parameter int SHIFT_STEP = 1    // legal: 1, 2, 4, 8
) (
    input  logic        clk,
    input  logic        rst,
    int_to_fp_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    fp32_t       res_q, res_d;
    logic        inexact_q, inexact_d;

    logic        in_neg;
    logic [31:0] in_mag;
    logic [3:0]  lz_w;
    logic        guard, sticky, round_up;
    logic [23:0] mant_rnd;

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_data    = res_q;
    assign bus.out_inexact = inexact_q;

    // Operand magnitude; negating 0x80000000 wraps back to 2^31, which is the wanted magnitude
    always_comb begin
        in_neg = bus.in_signed & bus.in_data[31];
        in_mag = in_neg ? (~bus.in_data + 32'd1) : bus.in_data;
    end

    // Leading zeros within the top SHIFT_STEP bits; lowest set index wins, all-zero gives SHIFT_STEP
    always_comb begin
        lz_w = 4'(SHIFT_STEP);
        for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
            if (mag_q[31 - i]) begin
                lz_w = 4'(i);
            end
        end
    end

    // Round-to-nearest-even on the normalised magnitude; bit 23 of mant_rnd is the carry-out
    always_comb begin
        guard    = mag_q[7];
        sticky   = |mag_q[6:0];
        round_up = guard & (sticky | mag_q[8]);
        mant_rnd = {1'b0, mag_q[30:8]} + 24'(round_up);
    end

    // Next-state and datapath update for the conversion sequence
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        res_d     = res_q;
        inexact_d = inexact_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = in_neg;
                    mag_d  = in_mag;
                    exp_d  = 8'd158;
                    if (in_mag == 32'd0) begin
                        // Zero skips normalisation and is always +0
                        res_d     = '0;
                        inexact_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (lz_w == 4'd0) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << lz_w;
                    exp_d = exp_q - 8'(lz_w);
                end
            end
            ROUND: begin
                // Mantissa carry leaves mant_rnd[22:0] at zero, so only the exponent moves
                res_d.sign = sign_q;
                res_d.exp  = exp_q + 8'(mant_rnd[23]);
                res_d.mant = mant_rnd[22:0];
                inexact_d  = guard | sticky;
                state_d    = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working operand and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q    <= 1'b0;
            mag_q     <= '0;
            exp_q     <= '0;
            res_q     <= '0;
            inexact_q <= 1'b0;
        end else begin
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            res_q     <= res_d;
            inexact_q <= inexact_d;
        end
    end

endmodule
